// File: rtl/signal_maker_pkg.sv
// Shared types and constants for the serial signal maker.
package signal_maker_pkg;

  typedef enum logic {
    SM_IDLE  = 1'b0,
    SM_SHIFT = 1'b1
  } sm_state_t;

  localparam logic SM_MSB_FIRST = 1'b0;
  localparam logic SM_LSB_FIRST = 1'b1;

endpackage

// File: rtl/sm_shift_reg.sv
// Parallel-load shift register; next_bit is the bit that becomes the
// outgoing bit after one more shift in the selected direction.
module sm_shift_reg
  import signal_maker_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             order,
  output logic             next_bit
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_val;
    end else if (shift) begin
      if (order == SM_LSB_FIRST) sr <= {1'b0, sr[WIDTH-1:1]};
      else                       sr <= {sr[WIDTH-2:0], 1'b0};
    end
  end

  assign next_bit = (order == SM_LSB_FIRST) ? sr[1] : sr[WIDTH-2];

endmodule

// File: rtl/signal_maker_ser.sv
// Serial pattern generator: shifts a captured WIDTH-bit word out one bit per
// clock, replays it rep+1 times back-to-back, with a graceful stop.
module signal_maker_ser
  import signal_maker_pkg::*;
#(
  parameter  int WIDTH = 6,
  parameter  int REP_W = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             lsb_first,
  input  logic [REP_W-1:0] rep,
  input  logic             stop,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  sm_state_t        state, next_state;
  logic [CNT_W-1:0] bit_cnt;
  logic [REP_W-1:0] frame_cnt;
  logic [WIDTH-1:0] shadow;
  logic             order_lsb;
  logic             stop_pend;

  logic accept, advance, reload, finish;
  logic last_bit;
  logic sr_next_bit;
  logic din_first, shadow_first;

  assign last_bit     = (bit_cnt == CNT_W'(WIDTH - 1));
  assign din_first    = (lsb_first == SM_LSB_FIRST) ? din[0] : din[WIDTH-1];
  assign shadow_first = (order_lsb == SM_LSB_FIRST) ? shadow[0] : shadow[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SM_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    advance    = 1'b0;
    reload     = 1'b0;
    finish     = 1'b0;
    case (state)
      SM_IDLE: begin
        if (load) begin
          accept     = 1'b1;
          next_state = SM_SHIFT;
        end
      end
      SM_SHIFT: begin
        if (!last_bit) begin
          advance = 1'b1;
        end else if ((frame_cnt != '0) && !stop_pend) begin
          reload = 1'b1;
        end else begin
          finish     = 1'b1;
          next_state = SM_IDLE;
        end
      end
      default: next_state = SM_IDLE;
    endcase
  end

  // dout is registered alongside the shift register: it always holds the bit
  // presented this cycle, while the shift register looks one bit ahead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      frame_cnt <= '0;
      shadow    <= '0;
      order_lsb <= SM_MSB_FIRST;
      stop_pend <= 1'b0;
      dout      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= finish;
      if (state == SM_SHIFT && stop) stop_pend <= 1'b1;
      if (accept) begin
        shadow    <= din;
        order_lsb <= lsb_first;
        frame_cnt <= rep;
        bit_cnt   <= '0;
        stop_pend <= 1'b0;
        dout      <= din_first;
      end else if (advance) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        dout    <= sr_next_bit;
      end else if (reload) begin
        frame_cnt <= frame_cnt - REP_W'(1);
        bit_cnt   <= '0;
        dout      <= shadow_first;
      end else if (finish) begin
        bit_cnt   <= '0;
        stop_pend <= 1'b0;
        dout      <= 1'b0;
      end
    end
  end

  sm_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (accept | reload),
    .load_val (accept ? din : shadow),
    .shift    (advance),
    .order    (order_lsb),
    .next_bit (sr_next_bit)
  );

  assign busy       = (state == SM_SHIFT);
  assign dout_valid = (state == SM_SHIFT);

endmodule

// File: tb/tb_signal_maker_ser.sv
// Bench for signal_maker_ser: transfer-level reference model checked every
// cycle, plus literal bit sequences for the directed scenarios.
module tb_signal_maker_ser;

  localparam int W = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [5:0] din = '0;
  logic       lsb_first = 1'b0;
  logic [3:0] rep = '0;
  logic       stop = 1'b0;
  logic       dout, dout_valid, busy, done;

  signal_maker_ser #(.WIDTH(6), .REP_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .din        (din),
    .lsb_first  (lsb_first),
    .rep        (rep),
    .stop       (stop),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Model: a transfer is a run of m_total bits indexed 0..m_total-1.
  int         m_idx = 0;
  int         m_total = 0;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic       m_lsb = 1'b0;
  logic [5:0] m_word = '0;

  // Stop seen while presenting bit idx+1 truncates after that bit's frame.
  function automatic int new_total(input int idx, input int tot, input logic s);
    int lim;
    if (!s) return tot;
    lim = ((idx + 1) / W + 1) * W;
    return (lim < tot) ? lim : tot;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_idx  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_total <= new_total(m_idx, m_total, stop);
        m_idx   <= m_idx + 1;
        if (m_idx + 1 == new_total(m_idx, m_total, stop)) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
      end else if (load) begin
        m_busy  <= 1'b1;
        m_idx   <= 0;
        m_total <= (int'(rep) + 1) * W;
        m_word  <= din;
        m_lsb   <= lsb_first;
      end
    end
  end

  function automatic logic exp_dout();
    int b;
    if (!m_busy) return 1'b0;
    b = m_idx % W;
    return m_lsb ? m_word[b] : m_word[W-1-b];
  endfunction

  int   n_cmp = 0;
  int   n_bad = 0;
  logic cap[$];
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("busy", 64'(busy), 64'(m_busy));
    chk("dout_valid", 64'(dout_valid), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("dout", 64'(dout), 64'(exp_dout()));
    if (dout_valid) cap.push_back(dout);
    if (done) done_cnt++;
  endtask

  task automatic start(input logic [5:0] d, input logic l, input logic [3:0] r);
    cap.delete();
    done_cnt  = 0;
    din       = d;
    lsb_first = l;
    rep       = r;
    load      = 1'b1;
    tick();
    load      = 1'b0;
  endtask

  task automatic wait_done(input int stop_at, input int load_at, input bit rnd);
    int k = 0;
    while (!done && k < 400) begin
      if (rnd) begin
        stop = ($urandom_range(0, 19) == 0);
        load = ($urandom_range(0, 9) == 0);
        din  = 6'($urandom);
      end else begin
        stop = (cap.size() == stop_at);
        load = (cap.size() == load_at);
        if (load) din = ~din;
      end
      tick();
      k++;
    end
    stop = 1'b0;
    load = 1'b0;
    chk("wait_done_timeout", 64'(k < 400), 64'd1);
  endtask

  task automatic check_cap(input string name, input logic [63:0] exp, input int len);
    logic [63:0] g = '0;
    foreach (cap[i]) g = {g[62:0], cap[i]};
    chk({name, "_len"}, 64'(cap.size()), 64'(len));
    chk({name, "_bits"}, g, exp);
  endtask

  initial begin
    int k;
    logic [3:0] r;

    tick();
    chk("reset_dout", 64'(dout), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();

    // stop in IDLE is ignored, then plain MSB-first frame
    stop = 1'b1;
    tick();
    stop = 1'b0;
    start(6'b100111, 1'b0, 4'd0);
    wait_done(-1, -1, 1'b0);
    check_cap("msb", 64'b100111, 6);
    chk("msb_done_cnt", 64'(done_cnt), 64'd1);
    tick();

    start(6'b100111, 1'b1, 4'd0);
    wait_done(-1, -1, 1'b0);
    check_cap("lsb", 64'b111001, 6);
    tick();

    start(6'b101100, 1'b0, 4'd2);
    wait_done(-1, -1, 1'b0);
    check_cap("rep2", 64'b101100101100101100, 18);
    chk("rep2_done_cnt", 64'(done_cnt), 64'd1);
    tick();

    // stop on bit 2 of frame 1
    start(6'b110010, 1'b0, 4'd3);
    wait_done(8, -1, 1'b0);
    check_cap("stop", 64'b110010110010, 12);
    chk("stop_done_cnt", 64'(done_cnt), 64'd1);

    // load in the done cycle starts immediately; mid-frame load ignored
    start(6'b110001, 1'b0, 4'd0);
    chk("load_in_done", {62'd0, dout_valid, dout}, 64'b11);
    wait_done(-1, 3, 1'b0);
    check_cap("ignore_load", 64'b110001, 6);
    tick();

    // asynchronous reset on bit 3 of frame 0
    start(6'b100111, 1'b0, 4'd1);
    k = 0;
    while (cap.size() < 4 && k < 50) begin
      tick();
      k++;
    end
    #2 rst = 1'b1;
    #1;
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_valid", 64'(dout_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    done_cnt = 0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("rst_no_done", 64'(done_cnt), 64'd0);
    start(6'b011010, 1'b1, 4'd0);
    wait_done(-1, -1, 1'b0);
    check_cap("post_rst", 64'b010110, 6);

    // randomized transfers with stray stop/load pulses
    repeat (40) begin
      repeat ($urandom_range(0, 3)) begin
        stop = 1'($urandom_range(0, 1));
        tick();
      end
      stop = 1'b0;
      r = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      start(6'($urandom), 1'($urandom_range(0, 1)), r);
      wait_done(-1, -1, 1'b1);
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
